// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the CPU/DMA requesters,
// the data-memory controller and the memory array.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [2:0]        cpu_funct3;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic              cpu_err;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_ready;
  logic [31:0]       dma_rdata;

  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_wdata, cpu_funct3,
    output dma_req, dma_we, dma_addr,
    output dma_wdata, mem_rdata,
    input  cpu_ready, cpu_rdata, cpu_err,
    input  dma_ready, dma_rdata,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_wdata, cpu_funct3,
    input  dma_req, dma_we, dma_addr,
    input  dma_wdata, mem_rdata,
    output cpu_ready, cpu_rdata, cpu_err,
    output dma_ready, dma_rdata,
    output mem_addr, mem_wdata,
    output mem_read, mem_write
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: CPU/DMA round-robin,
// sub-word load extraction and SB/SH read-modify-write.
module dmem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 10
) (
  input logic        clk,
  input logic        reset,
  dmem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, MERGE, DONE
  } state_e;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  state_e            state_q, state_d;
  logic              last_q;
  logic              gnt_q;
  logic              we_q;
  logic              err_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [15:0]       wlo_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wd_q;
  logic [31:0]       cpu_rd_q;
  logic [31:0]       dma_rd_q;

  logic              gnt_cpu, gnt_dma, grant;
  logic              s_we, ill;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [2:0]        s_f3;
  logic              rd, wr, done;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_ext, merged;
  logic              unused_ok;

  // last_q=1 means DMA won last, so CPU wins a tie
  assign gnt_cpu = bus.cpu_req
                 & (~bus.dma_req | last_q);
  assign gnt_dma = bus.dma_req & ~gnt_cpu;
  assign grant   = (state_q == IDLE)
                 & (gnt_cpu | gnt_dma);

  assign s_we    = gnt_dma ? bus.dma_we
                           : bus.cpu_we;
  assign s_addr  = gnt_dma
                 ? {bus.dma_addr[ADDR_W-1:2], 2'b00}
                 : bus.cpu_addr;
  assign s_wdata = gnt_dma ? bus.dma_wdata
                           : bus.cpu_wdata;
  assign s_f3    = gnt_dma ? F_W
                           : bus.cpu_funct3;

  always_comb begin
    ill = 1'b0;
    unique case (s_f3)
      F_B:     ill = 1'b0;
      F_BU:    ill = s_we;
      F_H:     ill = s_addr[0];
      F_HU:    ill = s_we | s_addr[0];
      F_W:     ill = |s_addr[1:0];
      default: ill = 1'b1;
    endcase
  end

  assign ld_b = bus.mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_h = off_q[1] ? bus.mem_rdata[31:16]
                         : bus.mem_rdata[15:0];

  always_comb begin
    ld_ext = bus.mem_rdata;
    unique case (f3_q)
      F_B:     ld_ext = {{24{ld_b[7]}}, ld_b};
      F_BU:    ld_ext = {24'h0, ld_b};
      F_H:     ld_ext = {{16{ld_h[15]}}, ld_h};
      F_HU:    ld_ext = {16'h0, ld_h};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merged = bus.mem_rdata;
    if (f3_q == F_H)
      merged[{off_q[1], 4'b0000} +: 16] = wlo_q;
    else
      merged[{off_q, 3'b000} +: 8] = wlo_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_cpu | gnt_dma)
          state_d = ill ? DONE : ACCESS;
      end
      ACCESS: begin
        if (!we_q) begin
          rd      = 1'b1;
          state_d = DONE;
        end else if (f3_q == F_W) begin
          wr      = 1'b1;
          state_d = DONE;
        end else begin
          rd      = 1'b1;
          state_d = MERGE;
        end
      end
      MERGE: begin
        wr      = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      off_q    <= 2'b00;
      f3_q     <= F_W;
      wlo_q    <= 16'h0;
      idx_q    <= '0;
      wd_q     <= 32'h0;
      cpu_rd_q <= 32'h0;
      dma_rd_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q <= gnt_dma;
        gnt_q  <= gnt_dma;
        we_q   <= s_we;
        off_q  <= s_addr[1:0];
        f3_q   <= s_f3;
        wlo_q  <= s_wdata[15:0];
        err_q  <= ill;
        if (!ill)
          idx_q <= s_addr[IDX_W+1:2];
        if (!ill && s_we && s_f3 == F_W)
          wd_q <= s_wdata;
      end
      if (state_q == ACCESS) begin
        if (!we_q) begin
          if (gnt_q) dma_rd_q <= bus.mem_rdata;
          else       cpu_rd_q <= ld_ext;
        end else if (f3_q != F_W) begin
          wd_q <= merged;
        end
      end
    end
  end

  assign done          = (state_q == DONE) & ~reset;
  assign bus.cpu_ready = done & ~gnt_q;
  assign bus.cpu_err   = done & ~gnt_q & err_q;
  assign bus.dma_ready = done & gnt_q;
  assign bus.cpu_rdata = cpu_rd_q;
  assign bus.dma_rdata = dma_rd_q;
  assign bus.mem_addr  = {{(32-IDX_W){1'b0}}, idx_q};
  assign bus.mem_wdata = wd_q;
  assign bus.mem_read  = rd & ~reset;
  assign bus.mem_write = wr & ~reset;

  assign unused_ok = ^{s_addr[ADDR_W-1:IDX_W+2],
                       bus.dma_addr[1:0]};

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table plus
// arbitration and reset-during-MERGE sequences.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dmem_ctrl_if #(.ADDR_W(32)) bus ();

  dmem_ctrl #(
    .ADDR_W(32),
    .IDX_W (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];

  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

  always @(posedge clk)
    if (bus.mem_write)
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

  int tests = 0;
  int fails = 0;
  int crdy  = 0;
  int drdy  = 0;
  int mwr   = 0;
  int both  = 0;

  always @(negedge clk) begin
    if (bus.cpu_ready) crdy++;
    if (bus.dma_ready) drdy++;
    if (bus.mem_write) mwr++;
    if (bus.mem_read && bus.mem_write) both++;
  end

  typedef struct {
    bit          dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          lat;
    bit          err;
    logic [31:0] rdata;
    int          idx;
    logic [31:0] memv;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic chk_rst_outs(input string p);
    chk({p, " cpu_ready"}, 32'(bus.cpu_ready), 0);
    chk({p, " dma_ready"}, 32'(bus.dma_ready), 0);
    chk({p, " cpu_err"},   32'(bus.cpu_err), 0);
    chk({p, " cpu_rdata"}, bus.cpu_rdata, 0);
    chk({p, " dma_rdata"}, bus.dma_rdata, 0);
    chk({p, " mem_addr"},  bus.mem_addr, 0);
    chk({p, " mem_wdata"}, bus.mem_wdata, 0);
    chk({p, " mem_read"},  32'(bus.mem_read), 0);
    chk({p, " mem_write"}, 32'(bus.mem_write), 0);
  endtask

  task automatic run_op(input vec_t t, input int n);
    int  c0, d0, m0, lat;
    bit  got, errv;
    @(negedge clk); #1;
    if (t.dma) begin
      bus.dma_req   = 1'b1;
      bus.dma_we    = t.we;
      bus.dma_addr  = t.addr;
      bus.dma_wdata = t.wdata;
    end else begin
      bus.cpu_req    = 1'b1;
      bus.cpu_we     = t.we;
      bus.cpu_addr   = t.addr;
      bus.cpu_wdata  = t.wdata;
      bus.cpu_funct3 = t.f3;
    end
    c0   = crdy;
    d0   = drdy;
    m0   = mwr;
    lat  = 1;
    got  = 1'b0;
    errv = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      lat++;
      got  = t.dma ? bus.dma_ready : bus.cpu_ready;
      errv = bus.cpu_err;
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    if (!got) lat = -1;
    chk($sformatf("v%0d latency", n),
        32'(lat), 32'(t.lat));
    chk($sformatf("v%0d err", n),
        32'(errv), 32'(t.err));
    chk($sformatf("v%0d rdata", n),
        t.dma ? bus.dma_rdata : bus.cpu_rdata,
        t.rdata);
    chk($sformatf("v%0d mem[%0d]", n, t.idx),
        mem[t.idx], t.memv);
    chk($sformatf("v%0d other ready", n),
        32'(t.dma ? crdy - c0 : drdy - d0), 0);
    if (t.err)
      chk($sformatf("v%0d no write", n),
          32'(mwr - m0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int   ev, c0;
    vec_t t;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 32'h0;
    bus.cpu_wdata  = 32'h0;
    bus.cpu_funct3 = 3'b010;
    bus.dma_req    = 1'b0;
    bus.dma_we     = 1'b0;
    bus.dma_addr   = 32'h0;
    bus.dma_wdata  = 32'h0;

    //        dma we addr    wdata         f3 lat err rdata  idx memv
    v[0]  = '{0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 3, 0,
              32'h0,        4,  32'hDEADBEEF};
    v[1]  = '{0, 0, 32'h10, 32'h0,        3'b010, 3, 0,
              32'hDEADBEEF, 4,  32'hDEADBEEF};
    v[2]  = '{0, 1, 32'h12, 32'h0000005A, 3'b000, 4, 0,
              32'hDEADBEEF, 4,  32'hDE5ABEEF};
    v[3]  = '{0, 0, 32'h13, 32'h0,        3'b000, 3, 0,
              32'hFFFFFFDE, 4,  32'hDE5ABEEF};
    v[4]  = '{0, 0, 32'h13, 32'h0,        3'b100, 3, 0,
              32'h000000DE, 4,  32'hDE5ABEEF};
    v[5]  = '{0, 0, 32'h12, 32'h0,        3'b101, 3, 0,
              32'h0000DE5A, 4,  32'hDE5ABEEF};
    v[6]  = '{0, 1, 32'h16, 32'h1234F00D, 3'b001, 4, 0,
              32'h0000DE5A, 5,  32'hF00D0000};
    v[7]  = '{0, 0, 32'h16, 32'h0,        3'b001, 3, 0,
              32'hFFFFF00D, 5,  32'hF00D0000};
    v[8]  = '{0, 0, 32'h11, 32'h0,        3'b000, 3, 0,
              32'hFFFFFFBE, 4,  32'hDE5ABEEF};
    v[9]  = '{0, 0, 32'h21, 32'h0,        3'b001, 2, 1,
              32'hFFFFFFBE, 8,  32'h0};
    v[10] = '{0, 1, 32'h22, 32'hCAFEF00D, 3'b010, 2, 1,
              32'hFFFFFFBE, 8,  32'h0};
    v[11] = '{0, 0, 32'h20, 32'h0,        3'b011, 2, 1,
              32'hFFFFFFBE, 8,  32'h0};
    v[12] = '{0, 1, 32'h20, 32'h000000FF, 3'b100, 2, 1,
              32'hFFFFFFBE, 8,  32'h0};
    v[13] = '{1, 1, 32'h43, 32'h0BADF00D, 3'b010, 3, 0,
              32'h0,        16, 32'h0BADF00D};
    v[14] = '{1, 0, 32'h40, 32'h0,        3'b010, 3, 0,
              32'h0BADF00D, 16, 32'h0BADF00D};

    repeat (3) @(negedge clk);
    #1;
    chk_rst_outs("reset");
    reset = 1'b0;
    @(negedge clk); #1;
    chk_rst_outs("post-reset");

    for (int i = 0; i < 15; i++) run_op(v[i], i);

    // reset lands on the MERGE cycle of an SH
    mem[2] = 32'hAAAAAAAA;
    @(negedge clk); #1;
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = 1'b1;
    bus.cpu_addr   = 32'h8;
    bus.cpu_wdata  = 32'h00001234;
    bus.cpu_funct3 = 3'b001;
    c0 = crdy;
    @(negedge clk); #1;
    chk("rmw access read", 32'(bus.mem_read), 1);
    @(negedge clk); #1;
    chk("rmw merge write", 32'(bus.mem_write), 1);
    chk("rmw merge wdata", bus.mem_wdata,
        32'hAAAA1234);
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk); #1;
    chk("abort mem[2]", mem[2], 32'hAAAAAAAA);
    chk_rst_outs("abort");
    reset = 1'b0;
    @(negedge clk); #1;
    chk("abort no ready", 32'(crdy - c0), 0);
    t = '{0, 0, 32'h8, 32'h0, 3'b010, 3, 0,
          32'hAAAAAAAA, 2, 32'hAAAAAAAA};
    run_op(t, 20);

    // contention: both hold requests every cycle
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk); #1;
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = 1'b1;
    bus.cpu_addr   = 32'h0;
    bus.cpu_wdata  = 32'h11111111;
    bus.cpu_funct3 = 3'b010;
    bus.dma_req    = 1'b1;
    bus.dma_we     = 1'b1;
    bus.dma_addr   = 32'h4;
    bus.dma_wdata  = 32'h22222222;
    ev = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk); #1;
      if (bus.cpu_ready && bus.dma_ready)
        chk("arb dual ready", 1, 0);
      if (bus.cpu_ready) begin
        chk($sformatf("arb ev%0d", ev),
            0, 32'(ev % 2));
        ev++;
      end
      if (bus.dma_ready) begin
        chk($sformatf("arb ev%0d", ev),
            1, 32'(ev % 2));
        ev++;
      end
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("arb count", 32'(ev >= 6), 1);
    chk("arb mem[0]", mem[0], 32'h11111111);
    chk("arb mem[1]", mem[1], 32'h22222222);
    chk("rd/wr overlap", 32'(both), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
